// File: rtl/vldu_trans_pkg.sv
// vldu_trans_pkg: shared types for the vector-unit address translation requester
// Holds the MMU exception record, the response record, the FSM state type,
// the access-fault cause codes and the timeout counter width helper.
package vldu_trans_pkg;
    localparam int unsigned VAddrW = 64;
    localparam int unsigned PAddrW = 56;
    localparam int unsigned XW     = 64;
    localparam int unsigned IdW    = 4;
    localparam logic [XW-1:0] LOAD_ACCESS_FAULT  = XW'(5);
    localparam logic [XW-1:0] STORE_ACCESS_FAULT = XW'(7);
    typedef struct packed {
        logic [XW-1:0] cause;
        logic [XW-1:0] tval;
        logic          valid;
    } exception_t;
    typedef struct packed {
        logic [IdW-1:0]    id;
        logic [PAddrW-1:0] paddr;
        logic              ex_valid;
        logic [XW-1:0]     ex_cause;
        logic [XW-1:0]     ex_tval;
        logic              timeout;
    } trans_rsp_t;
    typedef enum logic [1:0] {IDLE, WAIT, STALL} state_e;
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles);
    endfunction
endpackage

// File: rtl/vldu_addr_trans_req_fifo.sv
// vldu_addr_trans_req_fifo: registered response FIFO, head read straight from storage
// Ports: clk_i/rst_ni, push_i+data_i write, pop_i read, data_o head, full_o/empty_o status.
module vldu_addr_trans_req_fifo #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_q, rd_q;
    logic [AW:0]           cnt_q;
    logic                  do_push, do_pop;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_pop  = pop_i && !empty_o;
    // a push on full is accepted only when the same cycle frees a slot
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/vldu_addr_trans_req.sv
// vldu_addr_trans_req: issues one MMU translation at a time and queues the results
// Ports: req_* request stream in, mmu_* translation handshake, rsp_* response stream out,
// ex_pending_o / ex_clear_i sticky exception stall, en_translation_i bypass select.
module vldu_addr_trans_req
    import vldu_trans_pkg::*;
#(
    parameter int unsigned VLEN          = VAddrW,
    parameter int unsigned PLEN          = PAddrW,
    parameter int unsigned XLEN          = XW,
    parameter int unsigned IdWidth       = IdW,
    parameter int unsigned RspDepth      = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_translation_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [VLEN-1:0]    req_vaddr_i,
    input  logic               req_is_store_i,
    input  logic [IdWidth-1:0] req_id_i,
    output logic               mmu_req_o,
    output logic [VLEN-1:0]    mmu_vaddr_o,
    output logic               mmu_is_store_o,
    input  logic               mmu_valid_i,
    input  logic [PLEN-1:0]    mmu_paddr_i,
    input  exception_t         mmu_ex_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output trans_rsp_t         rsp_o,
    output logic               ex_pending_o,
    input  logic               ex_clear_i
);
    localparam int unsigned CntW = cnt_width(TimeoutCycles);
    state_e             state_q, state_d;
    logic [VLEN-1:0]    vaddr_q;
    logic               is_store_q;
    logic [IdWidth-1:0] id_q;
    logic [CntW-1:0]    cnt_q;
    logic               hs, mmu_done, timed_out, push, fifo_full, fifo_empty;
    trans_rsp_t         byp_rsp, mmu_rsp, tout_rsp, push_data, head;
    // the FSM only idles when no stall is pending, so IDLE alone implies !ex_pending
    assign req_ready_o  = rst_ni && state_q == IDLE && !fifo_full;
    assign hs           = req_valid_i && req_ready_o;
    assign mmu_done     = state_q == WAIT && mmu_valid_i;
    assign timed_out    = state_q == WAIT && !mmu_valid_i && cnt_q == CntW'(TimeoutCycles - 1);
    assign push         = (hs && !en_translation_i) || mmu_done || timed_out;
    assign mmu_req_o    = state_q == WAIT;
    assign mmu_vaddr_o  = vaddr_q;
    assign mmu_is_store_o = is_store_q;
    assign ex_pending_o = state_q == STALL;
    assign byp_rsp  = '{id: req_id_i, paddr: req_vaddr_i[PLEN-1:0], default: '0};
    assign mmu_rsp  = '{id: id_q, paddr: mmu_paddr_i, ex_valid: mmu_ex_i.valid,
                        ex_cause: mmu_ex_i.cause, ex_tval: mmu_ex_i.tval, timeout: 1'b0};
    assign tout_rsp = '{id: id_q, paddr: '0, ex_valid: 1'b1,
                        ex_cause: is_store_q ? STORE_ACCESS_FAULT : LOAD_ACCESS_FAULT,
                        ex_tval: XLEN'(vaddr_q), timeout: 1'b1};
    assign push_data = state_q == IDLE ? byp_rsp : mmu_valid_i ? mmu_rsp : tout_rsp;
    always_comb begin
        state_d = state_q == IDLE ? ((hs && en_translation_i) ? WAIT : IDLE)
                : state_q == WAIT ? (mmu_done ? (mmu_ex_i.valid ? STALL : IDLE)
                                              : (timed_out ? STALL : WAIT))
                : (ex_clear_i ? IDLE : STALL);
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            vaddr_q    <= '0;
            is_store_q <= 1'b0;
            id_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                vaddr_q    <= req_vaddr_i;
                is_store_q <= req_is_store_i;
                id_q       <= req_id_i;
            end
            cnt_q <= (state_q == WAIT && state_d == WAIT) ? cnt_q + 1'b1 : '0;
        end
    end
    vldu_addr_trans_req_fifo #(
        .DEPTH      (RspDepth),
        .DATA_WIDTH ($bits(trans_rsp_t))
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (rsp_ready_i),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
    assign rsp_valid_o = !fifo_empty;
    // stale storage is masked so an empty FIFO presents an all-zero response
    assign rsp_o       = fifo_empty ? '0 : head;
endmodule
